// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage-register enables/flushes, data-access completion tracking,
// halt latching and saturating stall/bubble counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRd,
    input  logic [4:0]       ex_wsel,
    input  logic             mem_MemRd,
    input  logic             mem_MemWr,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic [1:0]       mem_PCSrc,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             dmem_req,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DDONE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall_inc;
    logic             w_bubble_inc;

    logic w_mem_acc;
    logic w_dmem_ok;
    logic w_advance;
    logic w_redirect;
    logic w_loaduse;

    assign w_mem_acc  = mem_MemRd | mem_MemWr;
    assign w_dmem_ok  = !w_mem_acc | dhit | (r_state == DDONE);
    assign w_advance  = ihit & w_dmem_ok & (r_state != HALTED);
    assign w_redirect = (mem_branch & mem_zero) | (mem_PCSrc != 2'd0);
    assign w_loaduse  = ex_MemRd & (ex_wsel != 5'd0) &
                        ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    assign stall_cnt  = RST ? '0 : r_stall_cnt;
    assign bubble_cnt = RST ? '0 : r_bubble_cnt;

    // State register and saturating counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= RUN;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble_inc && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    // Next state and stage controls; everything stays low while RST is held
    always_comb begin
        w_state_nxt  = r_state;
        w_stall_inc  = 1'b0;
        w_bubble_inc = 1'b0;
        pc_en        = 1'b0;
        pc_redirect  = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        dmem_req     = 1'b0;
        halt         = 1'b0;

        if (!RST) begin
            if (r_state == HALTED) begin
                halt = 1'b1;
            end else begin
                dmem_req = w_mem_acc & (r_state == RUN);
                if (!w_advance) begin
                    w_stall_inc = 1'b1;
                    // Data finished while fetch is still waiting: remember it
                    if ((r_state == RUN) && w_mem_acc && dhit)
                        w_state_nxt = DDONE;
                end else begin
                    w_state_nxt = mem_halt ? HALTED : RUN;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    idex_en     = 1'b1;
                    if (w_redirect) begin
                        pc_en        = 1'b1;
                        pc_redirect  = 1'b1;
                        ifid_en      = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        w_bubble_inc = 1'b1;
                    end else if (w_loaduse) begin
                        idex_flush   = 1'b1;
                        w_bubble_inc = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates EN/flush for every stage register from three inputs: instruction/data cache hits, load-use hazards, and branch/jump resolution in MEM.
- Tracks completed data accesses so a dhit is never re-requested while the pipeline waits on ihit.
- Latches halt, and keeps saturating stall/bubble performance counters.

Parameters:
CNT_W, 32, width of stall_cnt and bubble_cnt

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
ihit  input  1  instruction fetch complete this cycle
dhit  input  1  data access complete this cycle
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
ex_MemRd  input  1  instruction in EX is a load
ex_wsel  input  5  destination register of instruction in EX
mem_MemRd  input  1  MEM-stage load
mem_MemWr  input  1  MEM-stage store
mem_branch  input  1  MEM-stage conditional branch
mem_zero  input  1  branch condition true (datapath pre-resolves BEQ/BNE polarity)
mem_PCSrc  input  2  00 sequential, nonzero = jump/JR/JAL in MEM
mem_halt  input  1  MEM-stage HALT
pc_en  output  1  PC load enable
pc_redirect  output  1  PC loads branch/jump target instead of pc+4
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register enables
ifid_flush, idex_flush, exmem_flush  output  1 each  stage register loads zeros (bubble)
dmem_req  output  1  data-cache request qualifier; datapath ANDs this with dREN/dWEN
halt  output  1  processor halted
stall_cnt  output  CNT_W  cycles the pipeline did not advance
bubble_cnt  output  CNT_W  bubbles inserted (load-use or redirect)

Behaviour:
- Flush is honoured only with its EN. The controller never asserts flush without the matching EN.
- State register: RUN, DDONE, HALTED.
- Reset (RST=1 at edge): state=RUN, stall_cnt=0, bubble_cnt=0.
  - While RST=1, every output is forced to 0, including halt and dmem_req.
- Derived terms:
  - mem_acc = mem_MemRd | mem_MemWr.
  - dmem_ok = !mem_acc | dhit | (state==DDONE).
  - advance = ihit & dmem_ok & (state!=HALTED).
  - redirect = mem_branch&mem_zero | (mem_PCSrc!=0).
  - loaduse = ex_MemRd & ex_wsel!=0 & (ex_wsel==id_rs | id_uses_rt & ex_wsel==id_rt).
- dmem_req = mem_acc & (state==RUN).
- !advance (RUN/DDONE): all EN=0, all flush=0, pc_redirect=0. stall_cnt+1.
- advance & redirect:
  - pc_en=1, pc_redirect=1; all four EN=1.
  - ifid_flush, idex_flush, exmem_flush = 1.
  - bubble_cnt+1.
  - Redirect overrides loaduse.
- advance & !redirect & loaduse:
  - pc_en=0, ifid_en=0.
  - idex_en=1 with idex_flush=1.
  - exmem_en=memwb_en=1.
  - bubble_cnt+1.
- advance, neither: pc_en and all EN=1, all flush=0.
- Transitions:
  - RUN -> DDONE: mem_acc & dhit & !ihit. The access is done, the pipeline is held, and dmem_req drops next cycle.
  - DDONE -> RUN: on ihit (advance).
  - DDONE holds while !ihit. dmem_req stays 0 even though mem_acc stays 1.
  - RUN/DDONE -> HALTED: advance & mem_halt. On that edge the MEM/WB register still loads, so the preceding instruction writes back.
  - HALTED: halt=1, all EN/flush/pc_en/dmem_req=0, counters frozen. Exit only by RST.
- Counters saturate at all-ones. They do not wrap.
- mem_halt with redirect in the same cycle: halt transition still taken. Redirect outputs are produced for that cycle only.
- RST mid-DDONE: returns to RUN. The outstanding-completion flag is lost, which is acceptable because the datapath registers are also reset.

Test Plan:
1. RST=1 for 2 cycles, then ihit=1, no hazards -> all EN=1, flush=0, pc_en=1, counters 0 in cycle 1, then stall_cnt=0 and bubble_cnt=0 after 10 cycles.
2. ex_MemRd=1, ex_wsel=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; bubble_cnt 0->1. Repeat with ex_wsel=0 -> no stall.
3. mem_MemRd=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0, then ihit=1 after 2 cycles:
   - dmem_req=1 for 4 cycles, then 0 in DDONE.
   - Advance on the ihit cycle.
   - stall_cnt=6.
4. mem_branch=1, mem_zero=1, loaduse also true, ihit=1 -> pc_redirect=1, ifid/idex/exmem_flush=1, pc_en=1; bubble_cnt+1 (not +2).
5. mem_halt=1 with ihit=1 -> that cycle memwb_en=1; next cycle halt=1, all EN 0, stall_cnt frozen. RST then clears halt=0.
6. Preload bubble_cnt near max using CNT_W=4 and 20 redirects -> bubble_cnt holds at 15.
